pipe_ctrl_unit: RTL and testbench
=================================

PIPE_CTRL_UNIT -- requirements
Module: pipe_ctrl_unit

Interface
REQ-001 SHALL have parameter RA_W, default 5, meaning register-address width.
REQ-002 SHALL have parameter IMM_LOGIC_EN, default 1, meaning that andi/ori/xori/slti are decoded; when 0 they decode as illegal.
REQ-003 SHALL have parameter CNT_W, default 16, meaning the width of the statistics counters.
REQ-004 SHALL have ports, clock and reset first:
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high
- id_opcode  in  6  opcode of the instruction in ID
- id_rs, id_rt  in  RA_W  source fields in ID
- ex_branch_taken  in  1  branch resolved taken in EX
- stall_ext  in  1  external freeze request
- ex_alu_src, ex_reg_dst, ex_branch  out  1  ID/EX control
- ex_alu_op  out  2  ID/EX ALU op
- mem_mem_read, mem_mem_write  out  1  EX/MEM control
- wb_reg_write, wb_mem_to_reg  out  1  MEM/WB control
- id_jump  out  1  combinational jump decode in ID
- pc_write, ifid_write  out  1  PC and IF/ID enables
- if_flush  out  1  squash IF/ID
- illegal_op  out  1  sticky illegal-opcode flag
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters

Function
REQ-005 Decode table, with bits in the order reg_write, mem_to_reg, branch, mem_read, mem_write, alu_src, reg_dst, jump, and alu_op after the slash:
- 000000 R: 1 0 0 0 0 0 1 0/10
- 100011 lw: 1 1 0 1 0 1 0 0/00
- 101011 sw: 0 0 0 0 1 1 0 0/00
- 000100 beq: 0 0 1 0 0 0 0 0/01
- 000010 j: 0 0 0 0 0 0 0 1/00
- 001000 addi: 1 0 0 0 0 1 0 0/00
- 001100/001101/001110/001010: 1 0 0 0 0 1 0 0/11
- any other opcode: all zero
REQ-006 An opcode outside REQ-005 (or an immediate-logic opcode when IMM_LOGIC_EN=0) SHALL decode as all zero and set illegal_op on the next edge; illegal_op SHALL clear only on reset.
REQ-007 The unit SHALL register its controls through a 3-stage chain, ID->EX->MEM->WB, so each decoded bit appears on its stage output 1, 2 or 3 cycles after decode.
REQ-008 The unit SHALL register ex_rt internally alongside the ID/EX controls.
REQ-009 The unit SHALL assert load-use hazard hz when ex_mem_read=1, ex_rt!=0, and ex_rt equals id_rs or id_rt.
REQ-010 Priority, with one action per cycle:
- stall_ext: every stage register holds; pc_write=0, ifid_write=0, if_flush=0; no counting.
- else ex_branch_taken: ID/EX loads a bubble (all control 0); EX/MEM and MEM/WB advance; if_flush=1; pc_write=1; ifid_write=1; flush_cnt+1.
- else hz: ID/EX loads a bubble; later stages advance; pc_write=0; ifid_write=0; stall_cnt+1.
- else normal: all stages advance; pc_write=1; ifid_write=1.
REQ-011 When not frozen, if_flush SHALL also equal 1 whenever id_jump=1, and a jump SHALL NOT stall.
REQ-012 stall_cnt and flush_cnt SHALL saturate at 2^CNT_W-1 with no wrap.
REQ-013 When a branch flush and a load-use hazard occur in the same cycle, the branch SHALL win, and no stall SHALL be counted.
REQ-014 The bubble path SHALL also clear ex_mem_read, so that a hazard never persists past one cycle for a single lw.

Reset
REQ-015 While reset=1 (asynchronous), all pipeline registers, illegal_op, stall_cnt, flush_cnt and ex_rt SHALL be 0.
REQ-016 While reset=1, pc_write=1, ifid_write=1 and if_flush=0.
REQ-017 After reset, the first valid outputs SHALL appear 1, 2 or 3 edges after the first decoded opcode.
REQ-018 A reset asserted mid-freeze or mid-stall SHALL discard all in-flight control.

Verification
REQ-019 Apply opcode 100011 for 1 cycle -> ex_alu_src=1 at +1; mem_mem_read=1 at +2; wb_reg_write=1 and wb_mem_to_reg=1 at +3.
REQ-020 Apply lw with rt=5, then the next instruction with R-type rs=5 -> pc_write=0 and ifid_write=0 for exactly 1 cycle; ID/EX holds a bubble; stall_cnt=1.
REQ-021 Apply lw with rt=0, then a consumer with rs=0 -> no stall, and stall_cnt stays 0.
REQ-022 Apply ex_branch_taken=1 together with a load-use hazard -> if_flush=1, pc_write=1, flush_cnt=1, stall_cnt=0.
REQ-023 Apply stall_ext=1 for 3 cycles mid-stream -> all stage outputs are held constant; counters do not change; then the pipeline resumes.
REQ-024 Apply opcode 111111, and opcode 001101 with IMM_LOGIC_EN=0 -> all controls 0 and illegal_op=1 until reset.
REQ-025 Drive stall_cnt preloaded near saturation by repeated hazards (CNT_W=2) -> it holds at 3.

Source files
------------

// File: rtl/pipe_ctrl_unit.sv
// Pipeline control for a classic 5-stage integer core: opcode decode, ID->EX->MEM->WB
// control chain, load-use interlock, branch/jump flush and saturating event counters.
module pipe_ctrl_unit #(
   parameter int          RA_W         = 5,
   parameter int unsigned IMM_LOGIC_EN = 1,
   parameter int          CNT_W        = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       id_opcode,
   input  logic [RA_W-1:0]  id_rs,
   input  logic [RA_W-1:0]  id_rt,
   input  logic             ex_branch_taken,
   input  logic             stall_ext,
   output logic             ex_alu_src,
   output logic             ex_reg_dst,
   output logic             ex_branch,
   output logic [1:0]       ex_alu_op,
   output logic             mem_mem_read,
   output logic             mem_mem_write,
   output logic             wb_reg_write,
   output logic             wb_mem_to_reg,
   output logic             id_jump,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             if_flush,
   output logic             illegal_op,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_SLTI  = 6'b001010;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef struct packed {
      logic       reg_write;
      logic       mem_to_reg;
      logic       branch;
      logic       mem_read;
      logic       mem_write;
      logic       alu_src;
      logic       reg_dst;
      logic       jump;
      logic [1:0] alu_op;
      logic       illegal;
   } dec_t;

   typedef struct packed {
      logic       reg_write;
      logic       mem_to_reg;
      logic       branch;
      logic       mem_read;
      logic       mem_write;
      logic       alu_src;
      logic       reg_dst;
      logic [1:0] alu_op;
   } idex_t;

   typedef struct packed {
      logic reg_write;
      logic mem_to_reg;
      logic mem_read;
      logic mem_write;
   } exmem_t;

   typedef struct packed {
      logic reg_write;
      logic mem_to_reg;
   } memwb_t;

   // One action per cycle, in priority order freeze > flush > stall > run.
   typedef enum logic [1:0] {
      ACT_RUN    = 2'd0,
      ACT_FREEZE = 2'd1,
      ACT_FLUSH  = 2'd2,
      ACT_STALL  = 2'd3
   } act_e;

   function automatic dec_t decode(input logic [5:0] op);
      dec_t d;
      d = '0;
      case (op)
         OP_RTYPE: begin
            d.reg_write = 1'b1;
            d.reg_dst   = 1'b1;
            d.alu_op    = 2'b10;
         end
         OP_LW: begin
            d.reg_write  = 1'b1;
            d.mem_to_reg = 1'b1;
            d.mem_read   = 1'b1;
            d.alu_src    = 1'b1;
         end
         OP_SW: begin
            d.mem_write = 1'b1;
            d.alu_src   = 1'b1;
         end
         OP_BEQ: begin
            d.branch = 1'b1;
            d.alu_op = 2'b01;
         end
         OP_J: d.jump = 1'b1;
         OP_ADDI: begin
            d.reg_write = 1'b1;
            d.alu_src   = 1'b1;
         end
         OP_ANDI, OP_ORI, OP_XORI, OP_SLTI: begin
            if (IMM_LOGIC_EN != 0) begin
               d.reg_write = 1'b1;
               d.alu_src   = 1'b1;
               d.alu_op    = 2'b11;
            end else begin
               d.illegal = 1'b1;
            end
         end
         default: d.illegal = 1'b1;
      endcase
      return d;
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_ONE;
   endfunction

   dec_t             dec;
   idex_t            id_ctrl;
   logic             hz_raw;
   logic             load_use;
   act_e             act;

   idex_t            idex_q, idex_d;
   logic [RA_W-1:0]  ex_rt_q, ex_rt_d;
   exmem_t           exmem_q, exmem_d;
   memwb_t           memwb_q, memwb_d;
   logic             illegal_q, illegal_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   always_comb begin
      dec                = decode(id_opcode);
      id_ctrl            = '0;
      id_ctrl.reg_write  = dec.reg_write;
      id_ctrl.mem_to_reg = dec.mem_to_reg;
      id_ctrl.branch     = dec.branch;
      id_ctrl.mem_read   = dec.mem_read;
      id_ctrl.mem_write  = dec.mem_write;
      id_ctrl.alu_src    = dec.alu_src;
      id_ctrl.reg_dst    = dec.reg_dst;
      id_ctrl.alu_op     = dec.alu_op;
   end

   // A jump never reads its register fields, so it must not be interlocked.
   always_comb begin
      hz_raw   = idex_q.mem_read && (ex_rt_q != '0) &&
                 ((ex_rt_q == id_rs) || (ex_rt_q == id_rt));
      load_use = hz_raw && !dec.jump;
      act      = ACT_RUN;
      if (stall_ext) begin
         act = ACT_FREEZE;
      end else if (ex_branch_taken) begin
         act = ACT_FLUSH;
      end else if (load_use) begin
         act = ACT_STALL;
      end
   end

   always_comb begin
      idex_d      = idex_q;
      ex_rt_d     = ex_rt_q;
      exmem_d     = exmem_q;
      memwb_d     = memwb_q;
      illegal_d   = illegal_q;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (act != ACT_FREEZE) begin
         exmem_d.reg_write  = idex_q.reg_write;
         exmem_d.mem_to_reg = idex_q.mem_to_reg;
         exmem_d.mem_read   = idex_q.mem_read;
         exmem_d.mem_write  = idex_q.mem_write;
         memwb_d.reg_write  = exmem_q.reg_write;
         memwb_d.mem_to_reg = exmem_q.mem_to_reg;
         if (act == ACT_RUN) begin
            idex_d    = id_ctrl;
            ex_rt_d   = id_rt;
            // Only an instruction that actually issues is flagged; a squashed one is not.
            illegal_d = illegal_q | dec.illegal;
         end else begin
            idex_d  = '0;
            ex_rt_d = '0;
         end
      end
      if (act == ACT_FLUSH) begin
         flush_cnt_d = sat_inc(flush_cnt_q);
      end
      if (act == ACT_STALL) begin
         stall_cnt_d = sat_inc(stall_cnt_q);
      end
   end

   always_comb begin
      pc_write   = 1'b1;
      ifid_write = 1'b1;
      if_flush   = 1'b0;
      case (act)
         ACT_FREEZE: begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
         end
         ACT_FLUSH: if_flush = 1'b1;
         ACT_STALL: begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
         end
         default: if_flush = dec.jump;
      endcase
      if (reset) begin
         pc_write   = 1'b1;
         ifid_write = 1'b1;
         if_flush   = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idex_q      <= '0;
         ex_rt_q     <= '0;
         exmem_q     <= '0;
         memwb_q     <= '0;
         illegal_q   <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         idex_q      <= idex_d;
         ex_rt_q     <= ex_rt_d;
         exmem_q     <= exmem_d;
         memwb_q     <= memwb_d;
         illegal_q   <= illegal_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign ex_alu_src    = idex_q.alu_src;
   assign ex_reg_dst    = idex_q.reg_dst;
   assign ex_branch     = idex_q.branch;
   assign ex_alu_op     = idex_q.alu_op;
   assign mem_mem_read  = exmem_q.mem_read;
   assign mem_mem_write = exmem_q.mem_write;
   assign wb_reg_write  = memwb_q.reg_write;
   assign wb_mem_to_reg = memwb_q.mem_to_reg;
   assign id_jump       = dec.jump;
   assign illegal_op    = illegal_q;
   assign stall_cnt     = stall_cnt_q;
   assign flush_cnt     = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Scoreboard bench for pipe_ctrl_unit: directed instruction stream, expectations queued
// per cycle and checked by an independent negedge monitor on two parameterisations.
module tb_pipe_ctrl_unit;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_ORI  = 6'b001101;
   localparam logic [5:0] OP_SLTI = 6'b001010;
   localparam logic [5:0] OP_BAD  = 6'b111111;

   localparam int S_EXSRC = 0,  S_EXDST = 1,  S_EXBR = 2,   S_EXOP = 3;
   localparam int S_MEMRD = 4,  S_MEMWR = 5,  S_WBRW = 6,   S_WBM2R = 7;
   localparam int S_JUMP  = 8,  S_PCW   = 9,  S_IFID = 10,  S_FLUSH = 11;
   localparam int S_ILL   = 12, S_SCNT  = 13, S_FCNT = 14,  S_ILL2 = 15;
   localparam int S_SCNT2 = 16, S_EXOP2 = 17, S_EXSRC2 = 18;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic [5:0] id_opcode;
   logic [4:0] id_rs, id_rt;
   logic       ex_branch_taken, stall_ext;

   logic        ex_alu_src, ex_reg_dst, ex_branch, mem_mem_read, mem_mem_write;
   logic        wb_reg_write, wb_mem_to_reg, id_jump, pc_write, ifid_write, if_flush, illegal_op;
   logic [1:0]  ex_alu_op;
   logic [15:0] stall_cnt, flush_cnt;

   logic        ex_alu_src2, ex_reg_dst2, ex_branch2, mem_mem_read2, mem_mem_write2;
   logic        wb_reg_write2, wb_mem_to_reg2, id_jump2, pc_write2, ifid_write2, if_flush2, illegal_op2;
   logic [1:0]  ex_alu_op2;
   logic [1:0]  stall_cnt2, flush_cnt2;

   pipe_ctrl_unit u_dut (
      .clk(clk), .reset(reset), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
      .ex_branch_taken(ex_branch_taken), .stall_ext(stall_ext),
      .ex_alu_src(ex_alu_src), .ex_reg_dst(ex_reg_dst), .ex_branch(ex_branch), .ex_alu_op(ex_alu_op),
      .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
      .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg), .id_jump(id_jump),
      .pc_write(pc_write), .ifid_write(ifid_write), .if_flush(if_flush), .illegal_op(illegal_op),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   pipe_ctrl_unit #(.RA_W(5), .IMM_LOGIC_EN(0), .CNT_W(2)) u_dut2 (
      .clk(clk), .reset(reset), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
      .ex_branch_taken(ex_branch_taken), .stall_ext(stall_ext),
      .ex_alu_src(ex_alu_src2), .ex_reg_dst(ex_reg_dst2), .ex_branch(ex_branch2), .ex_alu_op(ex_alu_op2),
      .mem_mem_read(mem_mem_read2), .mem_mem_write(mem_mem_write2),
      .wb_reg_write(wb_reg_write2), .wb_mem_to_reg(wb_mem_to_reg2), .id_jump(id_jump2),
      .pc_write(pc_write2), .ifid_write(ifid_write2), .if_flush(if_flush2), .illegal_op(illegal_op2),
      .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2)
   );

   typedef struct {
      int    at;
      int    sig;
      int    val;
      string name;
   } exp_t;

   exp_t sb[$];
   int   cyc   = 0;
   int   total = 0;
   int   bad   = 0;
   int   got_v;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int probe(input int s);
      case (s)
         S_EXSRC:  return int'(ex_alu_src);
         S_EXDST:  return int'(ex_reg_dst);
         S_EXBR:   return int'(ex_branch);
         S_EXOP:   return int'(ex_alu_op);
         S_MEMRD:  return int'(mem_mem_read);
         S_MEMWR:  return int'(mem_mem_write);
         S_WBRW:   return int'(wb_reg_write);
         S_WBM2R:  return int'(wb_mem_to_reg);
         S_JUMP:   return int'(id_jump);
         S_PCW:    return int'(pc_write);
         S_IFID:   return int'(ifid_write);
         S_FLUSH:  return int'(if_flush);
         S_ILL:    return int'(illegal_op);
         S_SCNT:   return int'(stall_cnt);
         S_FCNT:   return int'(flush_cnt);
         S_ILL2:   return int'(illegal_op2);
         S_SCNT2:  return int'(stall_cnt2);
         S_EXOP2:  return int'(ex_alu_op2);
         S_EXSRC2: return int'(ex_alu_src2);
         default:  return -1;
      endcase
   endfunction

   // Monitor: compares every queued expectation that falls due on this cycle.
   always @(negedge clk) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].at == cyc) begin
            total++;
            got_v = probe(sb[i].sig);
            if (got_v != sb[i].val) begin
               bad++;
               $display("FAIL %s cyc=%0d got=%0d want=%0d", sb[i].name, cyc, got_v, sb[i].val);
            end
            sb.delete(i);
         end else if (sb[i].at < cyc) begin
            total++;
            bad++;
            $display("FAIL %s missed cyc=%0d got=none want=%0d", sb[i].name, sb[i].at, sb[i].val);
            sb.delete(i);
         end
      end
   end

   task automatic want(input int ofs, input int s, input int v, input string nm);
      exp_t e;
      e.at   = cyc + ofs;
      e.sig  = s;
      e.val  = v;
      e.name = nm;
      sb.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic br, input logic sx);
      id_opcode       = op;
      id_rs           = rs;
      id_rt           = rt;
      ex_branch_taken = br;
      stall_ext       = sx;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      issue(OP_J, 5'd0, 5'd0, 1'b0, 1'b0);
      tick();
      tick();
      // Reset state, with a jump sitting in ID
      want(0, S_PCW, 1, "rst_pc_write");
      want(0, S_IFID, 1, "rst_ifid_write");
      want(0, S_FLUSH, 0, "rst_if_flush");
      want(0, S_JUMP, 1, "rst_id_jump");
      want(0, S_EXSRC, 0, "rst_ex_alu_src");
      want(0, S_MEMRD, 0, "rst_mem_read");
      want(0, S_WBRW, 0, "rst_wb_reg_write");
      want(0, S_ILL, 0, "rst_illegal");
      want(0, S_SCNT, 0, "rst_stall_cnt");
      want(0, S_FCNT, 0, "rst_flush_cnt");
      tick();
      reset = 1'b0;
      issue(OP_R, 5'd0, 5'd0, 1'b0, 1'b0);
      tick();

      // Decode table through the stage chain
      issue(OP_LW, 5'd0, 5'd0, 1'b0, 1'b0);
      want(1, S_EXSRC, 1, "lw_ex_alu_src");
      want(1, S_EXOP, 0, "lw_ex_alu_op");
      want(2, S_MEMRD, 1, "lw_mem_read");
      want(3, S_WBRW, 1, "lw_wb_reg_write");
      want(3, S_WBM2R, 1, "lw_wb_mem_to_reg");
      tick();
      issue(OP_R, 5'd0, 5'd0, 1'b0, 1'b0);
      want(1, S_EXDST, 1, "r_ex_reg_dst");
      want(1, S_EXSRC, 0, "r_ex_alu_src");
      want(1, S_EXOP, 2, "r_ex_alu_op");
      want(2, S_MEMRD, 0, "r_mem_read");
      want(3, S_WBM2R, 0, "r_wb_mem_to_reg");
      tick();
      issue(OP_BEQ, 5'd0, 5'd0, 1'b0, 1'b0);
      want(1, S_EXBR, 1, "beq_ex_branch");
      want(1, S_EXOP, 1, "beq_ex_alu_op");
      want(2, S_MEMWR, 0, "beq_mem_write");
      want(3, S_WBRW, 0, "beq_wb_reg_write");
      tick();
      issue(OP_SW, 5'd0, 5'd0, 1'b0, 1'b0);
      want(1, S_EXSRC, 1, "sw_ex_alu_src");
      want(1, S_EXBR, 0, "sw_ex_branch");
      want(2, S_MEMWR, 1, "sw_mem_write");
      want(3, S_WBRW, 0, "sw_wb_reg_write");
      tick();
      issue(OP_ADDI, 5'd0, 5'd0, 1'b0, 1'b0);
      want(0, S_FLUSH, 0, "addi_no_flush");
      want(1, S_EXSRC, 1, "addi_ex_alu_src");
      want(1, S_EXOP, 0, "addi_ex_alu_op");
      want(2, S_MEMWR, 0, "addi_mem_write");
      want(3, S_WBRW, 1, "addi_wb_reg_write");
      tick();
      issue(OP_J, 5'd0, 5'd0, 1'b0, 1'b0);
      want(0, S_JUMP, 1, "j_id_jump");
      want(0, S_FLUSH, 1, "j_if_flush");
      want(0, S_PCW, 1, "j_pc_write");
      want(1, S_EXSRC, 0, "j_ex_alu_src");
      want(1, S_EXOP, 0, "j_ex_alu_op");
      want(1, S_FCNT, 0, "j_flush_cnt");
      tick();
      issue(OP_ORI, 5'd0, 5'd0, 1'b0, 1'b0);
      want(1, S_EXOP, 3, "ori_ex_alu_op");
      want(1, S_EXSRC, 1, "ori_ex_alu_src");
      want(1, S_ILL, 0, "ori_legal");
      want(1, S_EXOP2, 0, "ori_dis_alu_op");
      want(1, S_EXSRC2, 0, "ori_dis_alu_src");
      want(1, S_ILL2, 1, "ori_dis_illegal");
      tick();
      issue(OP_SLTI, 5'd0, 5'd0, 1'b0, 1'b0);
      want(1, S_EXOP, 3, "slti_ex_alu_op");
      tick();

      // Branch flush coinciding with a load-use hazard
      issue(OP_LW, 5'd0, 5'd7, 1'b0, 1'b0);
      want(0, S_FCNT, 0, "brhz_flush_before");
      tick();
      issue(OP_R, 5'd7, 5'd0, 1'b1, 1'b0);
      want(0, S_FLUSH, 1, "brhz_if_flush");
      want(0, S_PCW, 1, "brhz_pc_write");
      want(0, S_IFID, 1, "brhz_ifid_write");
      want(1, S_FCNT, 1, "brhz_flush_cnt");
      want(1, S_SCNT, 0, "brhz_stall_cnt");
      want(1, S_SCNT2, 0, "brhz_stall_cnt2");
      want(1, S_EXDST, 0, "brhz_bubble");
      want(1, S_MEMRD, 1, "brhz_lw_advances");
      tick();
      issue(OP_R, 5'd0, 5'd0, 1'b0, 1'b0);
      want(0, S_FLUSH, 0, "brhz_after_flush");
      want(1, S_EXDST, 1, "brhz_after_ex");
      tick();

      // Load-use stall for exactly one cycle
      issue(OP_LW, 5'd0, 5'd5, 1'b0, 1'b0);
      want(0, S_PCW, 1, "lu_lw_pc_write");
      tick();
      issue(OP_R, 5'd5, 5'd0, 1'b0, 1'b0);
      want(0, S_PCW, 0, "lu_pc_write");
      want(0, S_IFID, 0, "lu_ifid_write");
      want(0, S_FLUSH, 0, "lu_if_flush");
      want(0, S_SCNT, 0, "lu_cnt_before");
      want(1, S_SCNT, 1, "lu_stall_cnt");
      want(1, S_SCNT2, 1, "lu_stall_cnt2");
      want(1, S_EXDST, 0, "lu_bubble_dst");
      want(1, S_EXOP, 0, "lu_bubble_op");
      want(1, S_MEMRD, 1, "lu_lw_advances");
      tick();
      issue(OP_R, 5'd5, 5'd0, 1'b0, 1'b0);
      want(0, S_PCW, 1, "lu_release_pc");
      want(0, S_IFID, 1, "lu_release_ifid");
      want(1, S_EXDST, 1, "lu_consumer_issues");
      want(1, S_SCNT, 1, "lu_cnt_once");
      tick();

      // Load into r0 never interlocks
      issue(OP_LW, 5'd0, 5'd0, 1'b0, 1'b0);
      tick();
      issue(OP_R, 5'd0, 5'd0, 1'b0, 1'b0);
      want(0, S_PCW, 1, "r0_no_stall");
      want(1, S_SCNT, 1, "r0_cnt_same");
      tick();

      // Jump reading a loaded register neither stalls nor counts
      issue(OP_LW, 5'd0, 5'd5, 1'b0, 1'b0);
      tick();
      issue(OP_J, 5'd5, 5'd0, 1'b0, 1'b0);
      want(0, S_PCW, 1, "jhz_pc_write");
      want(0, S_IFID, 1, "jhz_ifid_write");
      want(0, S_FLUSH, 1, "jhz_if_flush");
      want(1, S_SCNT, 1, "jhz_stall_cnt");
      want(1, S_FCNT, 1, "jhz_flush_cnt");
      tick();

      // External freeze for three cycles mid-stream
      issue(OP_R, 5'd0, 5'd0, 1'b0, 1'b0);
      tick();
      issue(OP_LW, 5'd0, 5'd0, 1'b0, 1'b0);
      want(1, S_EXSRC, 1, "frz_lw_ex");
      tick();
      issue(OP_R, 5'd0, 5'd0, 1'b0, 1'b0);
      want(1, S_EXDST, 1, "frz_r_ex");
      tick();
      for (int k = 0; k < 3; k++) begin
         issue((k == 2) ? OP_J : OP_BEQ, 5'd0, 5'd0, (k == 1), 1'b1);
         want(0, S_PCW, 0, "frz_pc_write");
         want(0, S_IFID, 0, "frz_ifid_write");
         want(0, S_FLUSH, 0, "frz_if_flush");
         want(1, S_EXDST, 1, "frz_hold_ex_dst");
         want(1, S_EXBR, 0, "frz_hold_ex_br");
         want(1, S_EXOP, 2, "frz_hold_ex_op");
         want(1, S_MEMRD, 1, "frz_hold_mem");
         want(1, S_WBM2R, 0, "frz_hold_wb_m2r");
         want(1, S_WBRW, 1, "frz_hold_wb_rw");
         want(1, S_SCNT, 1, "frz_stall_cnt");
         want(1, S_FCNT, 1, "frz_flush_cnt");
         tick();
      end
      issue(OP_BEQ, 5'd0, 5'd0, 1'b0, 1'b0);
      want(0, S_PCW, 1, "frz_resume_pc");
      want(1, S_EXBR, 1, "frz_resume_ex");
      want(1, S_MEMRD, 0, "frz_resume_mem");
      want(1, S_WBM2R, 1, "frz_resume_wb");
      tick();

      // Repeated hazards: 16-bit counter keeps counting, 2-bit one sticks at 3
      for (int i = 0; i < 4; i++) begin
         issue(OP_LW, 5'd0, 5'd9, 1'b0, 1'b0);
         tick();
         issue(OP_R, (i % 2 == 0) ? 5'd9 : 5'd0, (i % 2 == 0) ? 5'd0 : 5'd9, 1'b0, 1'b0);
         want(0, S_PCW, 0, "rep_pc_write");
         want(1, S_SCNT, 2 + i, "rep_stall_cnt");
         want(1, S_SCNT2, (2 + i > 3) ? 3 : 2 + i, "rep_stall_cnt2_sat");
         tick();
         want(0, S_PCW, 1, "rep_release");
         tick();
      end

      // Illegal opcode
      issue(OP_BAD, 5'd0, 5'd0, 1'b0, 1'b0);
      want(0, S_ILL, 0, "bad_before");
      want(0, S_JUMP, 0, "bad_no_jump");
      want(0, S_FLUSH, 0, "bad_no_flush");
      want(1, S_ILL, 1, "bad_illegal");
      want(1, S_EXSRC, 0, "bad_ex_src");
      want(1, S_EXDST, 0, "bad_ex_dst");
      want(1, S_EXOP, 0, "bad_ex_op");
      want(1, S_EXBR, 0, "bad_ex_br");
      want(2, S_MEMRD, 0, "bad_mem_read");
      want(2, S_MEMWR, 0, "bad_mem_write");
      want(3, S_WBRW, 0, "bad_wb_reg_write");
      want(3, S_WBM2R, 0, "bad_wb_m2r");
      tick();
      issue(OP_R, 5'd0, 5'd0, 1'b0, 1'b0);
      repeat (3) tick();
      want(0, S_ILL, 1, "bad_sticky");
      want(0, S_ILL2, 1, "dis_sticky");

      // Reset in the middle of a freeze discards everything
      issue(OP_LW, 5'd0, 5'd5, 1'b0, 1'b0);
      tick();
      issue(OP_R, 5'd5, 5'd0, 1'b0, 1'b1);
      #1;
      reset = 1'b1;
      want(0, S_EXSRC, 0, "mrst_ex");
      want(0, S_MEMRD, 0, "mrst_mem");
      want(0, S_WBRW, 0, "mrst_wb");
      want(0, S_ILL, 0, "mrst_illegal");
      want(0, S_ILL2, 0, "mrst_illegal2");
      want(0, S_SCNT, 0, "mrst_stall_cnt");
      want(0, S_SCNT2, 0, "mrst_stall_cnt2");
      want(0, S_FCNT, 0, "mrst_flush_cnt");
      want(0, S_PCW, 1, "mrst_pc_write");
      want(0, S_IFID, 1, "mrst_ifid_write");
      want(0, S_FLUSH, 0, "mrst_if_flush");
      tick();
      issue(OP_J, 5'd0, 5'd0, 1'b0, 1'b0);
      want(0, S_FLUSH, 0, "mrst_j_no_flush");
      want(0, S_PCW, 1, "mrst_j_pc");
      tick();
      reset = 1'b0;
      issue(OP_LW, 5'd0, 5'd0, 1'b0, 1'b0);
      want(1, S_EXSRC, 1, "post_lw_ex");
      want(1, S_ILL, 0, "post_illegal");
      want(1, S_SCNT, 0, "post_stall_cnt");
      want(2, S_MEMRD, 1, "post_lw_mem");
      want(3, S_WBRW, 1, "post_lw_wb");
      want(3, S_WBM2R, 1, "post_lw_wb_m2r");
      tick();
      issue(OP_R, 5'd0, 5'd0, 1'b0, 1'b0);
      repeat (5) tick();

      foreach (sb[i]) begin
         total++;
         bad++;
         $display("FAIL %s pending at=%0d got=none want=%0d", sb[i].name, sb[i].at, sb[i].val);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
